// File: rtl/kyber_pkg.sv
// Shared constants, FSM state type and the legal compression-width check
// used by the polynomial decompressor.
package kyber_pkg;

  localparam int unsigned KYBER_Q = 3329;
  localparam int unsigned KYBER_N = 256;
  localparam int unsigned D_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic legal_d(input logic [D_W-1:0] dv);
    case (dv)
      4'd1, 4'd4, 4'd5, 4'd10, 4'd11: legal_d = 1'b1;
      default:                        legal_d = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decompress_module.sv
// Combinational coefficient decompression: round(x * q / 2^d).
module decompress_module
  import kyber_pkg::*;
(
  input  logic [15:0] x,
  input  logic [15:0] d,
  output logic [15:0] result
);

  logic [31:0] round_c;
  logic [31:0] prod_c;

  always_comb begin
    round_c = (d == 16'd0) ? 32'd0 : (32'd1 << (d - 16'd1));
    prod_c  = 32'(x) * 32'(KYBER_Q) + round_c;
    result  = 16'(prod_c >> d);
  end

endmodule

// File: rtl/poly_decompress.sv
// Unpacks an LSB-first byte stream into 256 d-bit fields and emits one
// decompressed coefficient per field on a registered valid/ready stream.
module poly_decompress
  import kyber_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  d,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_coeff,
  output logic        out_last
);

  localparam int unsigned BUF_W      = 24;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned BYTE_CNT_W = 9;
  localparam int unsigned COEF_CNT_W = 8;

  state_t                 state, state_nx;
  logic [D_W-1:0]         d_q, d_nx;
  logic [BUF_W-1:0]       bits, bits_nx;
  logic [CNT_W-1:0]       cnt, cnt_nx;
  logic [BYTE_CNT_W-1:0]  byte_cnt, byte_cnt_nx;
  logic [COEF_CNT_W-1:0]  coef_cnt, coef_cnt_nx;
  logic                   busy_nx, done_nx, err_nx, in_ready_nx;
  logic                   out_valid_nx, out_last_nx;
  logic [15:0]            out_coeff_nx;

  logic [BYTE_CNT_W-1:0]  total_c, total_nx_c;
  logic [CNT_W-1:0]       dw_c, pop_w_c, rem_c;
  logic                   push_c, hs_c, pop_c;
  logic [15:0]            field_c, result_c;

  decompress_module u_decompress (
    .x      (field_c),
    .d      (16'(d_q)),
    .result (result_c)
  );

  // Next-state, bit-buffer and output-register logic
  always_comb begin
    total_c  = {d_q, 5'b0};
    dw_c     = {1'b0, d_q};
    push_c   = in_valid && in_ready;
    hs_c     = out_valid && out_ready;
    pop_c    = (state == RUN) && (cnt >= dw_c) && (!out_valid || out_ready);
    pop_w_c  = pop_c ? dw_c : '0;
    field_c  = 16'(bits & ((BUF_W'(1) << dw_c) - BUF_W'(1)));
    rem_c    = cnt - pop_w_c;

    state_nx     = state;
    d_nx         = d_q;
    err_nx       = 1'b0;
    bits_nx      = bits >> pop_w_c;
    cnt_nx       = rem_c + (push_c ? CNT_W'(8) : CNT_W'(0));
    byte_cnt_nx  = byte_cnt + BYTE_CNT_W'(push_c);
    coef_cnt_nx  = coef_cnt + COEF_CNT_W'(hs_c);
    out_valid_nx = out_valid;
    out_coeff_nx = out_coeff;
    out_last_nx  = out_last;

    // Newly accepted byte lands directly above the bits still buffered
    if (push_c) begin
      bits_nx = bits_nx | (BUF_W'(in_data) << rem_c);
    end

    if (pop_c) begin
      out_valid_nx = 1'b1;
      out_coeff_nx = result_c;
      out_last_nx  = (byte_cnt == total_c) && (cnt == dw_c);
    end else if (hs_c) begin
      out_valid_nx = 1'b0;
      out_last_nx  = 1'b0;
    end

    case (state)
      IDLE: begin
        if (start) begin
          if (legal_d(d)) begin
            state_nx    = RUN;
            d_nx        = d;
            bits_nx     = '0;
            cnt_nx      = '0;
            byte_cnt_nx = '0;
            coef_cnt_nx = '0;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      RUN: begin
        if (hs_c && (coef_cnt == COEF_CNT_W'(KYBER_N - 1))) begin
          state_nx    = DONE;
          byte_cnt_nx = '0;
          coef_cnt_nx = '0;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    total_nx_c  = {d_nx, 5'b0};
    busy_nx     = (state_nx == RUN);
    done_nx     = (state_nx == DONE);
    in_ready_nx = (state_nx == RUN) && (byte_cnt_nx < total_nx_c) &&
                  (cnt_nx <= CNT_W'(16));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      d_q       <= '0;
      bits      <= '0;
      cnt       <= '0;
      byte_cnt  <= '0;
      coef_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_coeff <= 16'd0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_nx;
      d_q       <= d_nx;
      bits      <= bits_nx;
      cnt       <= cnt_nx;
      byte_cnt  <= byte_cnt_nx;
      coef_cnt  <= coef_cnt_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      err       <= err_nx;
      in_ready  <= in_ready_nx;
      out_valid <= out_valid_nx;
      out_coeff <= out_coeff_nx;
      out_last  <= out_last_nx;
    end
  end

endmodule

// File: tb/tb_poly_decompress.sv
// Directed bench for poly_decompress: legal widths, back-pressure,
// illegal-width error, ignored start while busy and mid-run reset.
module tb_poly_decompress;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  d;
  logic        busy, done, err;
  logic        in_valid, in_ready;
  logic [7:0]  in_data;
  logic        out_valid, out_ready;
  logic [15:0] out_coeff;
  logic        out_last;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] bytes [0:351];
  int         got_c [0:255];
  bit         got_l [0:255];
  int         ncoef;
  int         hs_last_cyc;
  int         done_cyc;

  always #5 clk = ~clk;

  poly_decompress dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .d         (d),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coeff (out_coeff),
    .out_last  (out_last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: unpack field k LSB-first and round(x*3329/2^d)
  function automatic int model(input int dd, input int k);
    longint x = 0;
    for (int j = 0; j < dd; j++) begin
      int         pos = k * dd + j;
      logic [7:0] bv  = bytes[pos / 8];
      if (bv[pos % 8]) x = x | (longint'(1) << j);
    end
    return int'((x * 3329 + (longint'(1) << (dd - 1))) >> dd);
  endfunction

  task automatic clear_bytes();
    for (int i = 0; i < 352; i++) bytes[i] = 8'h00;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_last"}, 32'(out_last), 32'd0);
    check({tag, "_out_coeff"}, 32'(out_coeff), 32'd0);
  endtask

  task automatic run_poly(input int dd, input int stall_at, input int stall_len,
                          input int busy_start_at, input int abort_at);
    int   bi = 0;
    int   cyc = 0;
    int   stall_left = 0;
    bit   stall_used = 0;
    bit   held_ok = 0;
    bit   dropped = 0;
    bit   finished = 0;
    logic [15:0] held = '0;
    ncoef = 0; hs_last_cyc = -1; done_cyc = -1;
    @(negedge clk); start = 1'b1; d = 4'(dd);
    @(negedge clk); start = 1'b0; d = 4'd0;
    check("busy_after_start", 32'(busy), 32'd1);
    while (!finished && cyc < 3000) begin
      if (done) begin
        done_cyc = cyc;
        finished = 1;
      end else begin
        start = (busy_start_at >= 0) && (ncoef == busy_start_at);
        d     = start ? 4'd4 : 4'd0;
        if (stall_at >= 0 && !stall_used && ncoef == stall_at) begin
          stall_used = 1; stall_left = stall_len;
        end
        out_ready = (stall_left == 0);
        if (stall_left > 0) begin
          if (!in_ready) dropped = 1;
          if (out_valid) begin
            if (!held_ok) begin held = out_coeff; held_ok = 1; end
            else check("stall_hold", 32'(out_coeff), 32'(held));
          end
          stall_left--;
        end
        in_valid = (bi < 32 * dd);
        in_data  = in_valid ? bytes[bi] : 8'h00;
        if (in_valid && in_ready) bi++;
        if (out_valid && out_ready) begin
          if (ncoef < 256) begin got_c[ncoef] = out_coeff; got_l[ncoef] = out_last; end
          ncoef++;
          hs_last_cyc = cyc;
        end
        if (abort_at >= 0 && ncoef == abort_at) finished = 1;
        else begin @(negedge clk); cyc++; end
      end
    end
    start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    if (!finished) check("timeout", 32'd0, 32'd1);
    if (stall_at >= 0) check("stall_in_ready_drop", 32'(dropped), 32'd1);
  endtask

  task automatic verify_run(input string tag, input int dd);
    int nlast = 0;
    check({tag, "_count"}, 32'(ncoef), 32'd256);
    for (int k = 0; k < 256 && k < ncoef; k++) begin
      check({tag, "_coeff"}, 32'(got_c[k]), 32'(model(dd, k)));
      if (got_l[k]) nlast++;
    end
    check({tag, "_last_count"}, 32'(nlast), 32'd1);
    check({tag, "_last_pos"}, 32'(got_l[255]), 32'd1);
    check({tag, "_done_latency"}, 32'(done_cyc - hs_last_cyc), 32'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; d = 4'd0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Illegal width
    start = 1'b1; d = 4'd3;
    @(negedge clk); start = 1'b0; d = 4'd0;
    check("err_pulse", 32'(err), 32'd1);
    check("err_busy", 32'(busy), 32'd0);
    check("err_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("err_clears", 32'(err), 32'd0);

    // d=1 all ones, with an ignored start mid-run
    for (int i = 0; i < 352; i++) bytes[i] = 8'hFF;
    run_poly(1, -1, 0, 10, -1);
    check("d1_coeff0", 32'(got_c[0]), 32'd1665);
    check("d1_coeff255", 32'(got_c[255]), 32'd1665);
    verify_run("d1", 1);

    // d=4 nibble pattern
    clear_bytes(); bytes[0] = 8'hF0; bytes[1] = 8'h0F;
    run_poly(4, -1, 0, -1, -1);
    check("d4_c0", 32'(got_c[0]), 32'd0);
    check("d4_c1", 32'(got_c[1]), 32'd3121);
    check("d4_c2", 32'(got_c[2]), 32'd3121);
    check("d4_c3", 32'(got_c[3]), 32'd0);
    verify_run("d4", 4);

    // d=10 five bytes of ones
    clear_bytes();
    for (int i = 0; i < 5; i++) bytes[i] = 8'hFF;
    run_poly(10, -1, 0, -1, -1);
    for (int k = 0; k < 4; k++) check("d10_max", 32'(got_c[k]), 32'd3326);
    check("d10_c4", 32'(got_c[4]), 32'd0);
    verify_run("d10", 10);

    // d=5 max field
    clear_bytes(); bytes[0] = 8'h1F;
    run_poly(5, -1, 0, -1, -1);
    check("d5_max", 32'(got_c[0]), 32'd3225);
    check("d5_c1", 32'(got_c[1]), 32'd0);
    verify_run("d5", 5);

    // d=11 with a 20-cycle output stall mid-stream
    for (int i = 0; i < 352; i++) bytes[i] = 8'((i * 37 + 5) % 256);
    bytes[0] = 8'hFF; bytes[1] = 8'h07;
    run_poly(11, 50, 20, -1, -1);
    check("d11_max", 32'(got_c[0]), 32'd3327);
    verify_run("d11", 11);

    // Reset after 100 coefficients, then a fresh d=4 run
    for (int i = 0; i < 352; i++) bytes[i] = 8'((i * 73 + 11) % 256);
    run_poly(4, -1, 0, -1, 100);
    rst = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    check_idle_outputs("midrun_reset");
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");
    run_poly(4, -1, 0, -1, -1);
    verify_run("d4_after_reset", 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/poly_decompress.md
POLY_DECOMPRESS -- requirements
Module: poly_decompress

Interface
REQ-001 The block SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 The block SHALL have ports: rst  input  1  synchronous, active-high reset.
REQ-003 The block SHALL have ports: start  input  1  one-cycle request to begin one polynomial.
REQ-004 The block SHALL have ports: d  input  4  compression width, sampled only on an accepted start.
REQ-005 The block SHALL have ports: busy  output  1  high from an accepted start until done.
REQ-006 The block SHALL have ports: done  output  1  one-cycle pulse after the final coefficient handshake.
REQ-007 The block SHALL have ports: err  output  1  one-cycle pulse when start carries an illegal d.
REQ-008 The block SHALL have ports: in_valid / in_ready / in_data[7:0]  input / output / input  packed byte stream.
REQ-009 The block SHALL have ports: out_valid / out_ready / out_coeff[15:0] / out_last  output / input / output / output  coefficient stream.
REQ-010 The block SHALL use one clock (clk); reset (rst) SHALL be synchronous and active-high.

Function
REQ-011 The legal d values SHALL be {1,4,5,10,11}.
REQ-012 States SHALL be IDLE, RUN and DONE: IDLE->RUN on start with a legal d; RUN->DONE on the 256th output handshake; DONE->IDLE unconditionally after 1 cycle, with done=1 in DONE.
REQ-013 A start with an illegal d in IDLE SHALL pulse err the next cycle and leave the block in IDLE; start while not in IDLE SHALL be ignored.
REQ-014 In RUN the block SHALL accept exactly 32*d bytes; in_ready=1 only in RUN, with bytes remaining, and bit-buffer count <=16 (24-bit buffer).
REQ-015 Bit order SHALL be LSB-first: each new byte is appended above the current buffered bits, and each field is taken from buffer bits [d-1:0].
REQ-016 A field SHALL be extracted when the count is >= d and the output register is empty or is handshaking in the same cycle.
REQ-017 A byte push and a field pop in the same cycle SHALL be legal, giving new count = count + 8 - d.
REQ-018 Each field x SHALL map to out_coeff = (x*3329 + 2^(d-1)) >> d, zero-extended to 16 bits; the product SHALL be at least 23 bits wide with no truncation.
REQ-019 out_coeff SHALL be registered: the coefficient appears 1 cycle after extraction.
REQ-020 out_coeff and out_last SHALL be held stable while out_valid=1 and out_ready=0.
REQ-021 out_last SHALL be 1 only with the 256th coefficient.
REQ-022 After the last handshake the byte counter, coefficient counter and bit-buffer count SHALL all be zero.

Reset
REQ-023 On rst=1 the block SHALL enter IDLE and clear the counters, bit buffer and latched d.
REQ-024 On rst=1 busy, done, err, in_ready, out_valid and out_last SHALL be 0 and out_coeff SHALL be 16'd0.
REQ-025 A reset during RUN SHALL discard partial data; the first cycle after reset SHALL be IDLE with all outputs 0.

Structure
REQ-026 KYBER_Q=3329, KYBER_N=256, the state enum and a legal-d check function SHALL live in kyber_pkg.
REQ-027 The per-coefficient arithmetic SHALL be one combinational sub-module, decompress_module (x[15:0], d[15:0] -> result[15:0]), instantiated once.

Verification
REQ-028 Scenario: d=1, 32 bytes of 0xFF, out_ready=1 -> 256 coefficients of 1665, out_last on the 256th, done the next cycle.
REQ-029 Scenario: d=4, bytes 0xF0 then 0x0F, rest 0x00 -> coefficients 0, 3121, 3121, 0, then zeros.
REQ-030 Scenario: d=10, five bytes of 0xFF -> four coefficients of 3326; d=11 field 2047 -> 3327; d=5 field 31 -> 3225.
REQ-031 Scenario: d=11, out_ready held low for 20 cycles mid-stream -> out_coeff stable, in_ready drops once count >16, no loss or duplication after release.
REQ-032 Scenario: start with d=3 -> err pulse, busy=0, in_ready=0; a start while busy is ignored.
REQ-033 Scenario: rst asserted after 100 coefficients -> next cycle all outputs 0; a fresh d=4 run completes correctly.
